// File: rtl/conv_apb_sequencer.sv
// -----------------------------------------------------------------------------
// conv_apb_sequencer
//
// APB master that shares a single Gray-code/SPI converter slave between N_REQ
// requesters. A round-robin arbiter picks one requester per job. Each job does
// the following:
//   1. writes the operand (addr 0)
//   2. starts the converter (addr 4, data 8'h01)
//   3. polls control (addr 4) until the end flag bit 1 is set
//   4. reads the result (addr 2)
// It then reports the outcome on the rsp_* fields with a one-cycle ack.
//
// Ports
//   clk, rst_n        clock (rising edge) / asynchronous active-low reset
//   req[N_REQ]        per-requester job request, held until ack
//   req_operand       operand of requester i at bits [8i+7:8i]
//   ack[N_REQ]        one-cycle pulse to the served requester at job end
//   rsp_valid         one-cycle pulse, rsp_* valid
//   rsp_id            served requester index
//   rsp_result        result register value (0 on timeout)
//   rsp_err           control[7] seen at completion (0 on timeout)
//   rsp_timeout       job aborted by poll limit or pready limit
//   busy              high from the cycle after grant through DONE
//   paddr/pwdata/psel/penable/pwrite   APB master outputs (all registered)
//   pready/prdata     APB slave response
// -----------------------------------------------------------------------------
module conv_apb_sequencer #(
    parameter int N_REQ      = 2,
    parameter int POLL_MAX   = 64,
    parameter int PREADY_MAX = 16,
    localparam int ID_W      = (N_REQ > 1) ? $clog2(N_REQ) : 1
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [N_REQ-1:0]     req,
    input  logic [8*N_REQ-1:0]   req_operand,
    output logic [N_REQ-1:0]     ack,
    output logic                 rsp_valid,
    output logic [ID_W-1:0]      rsp_id,
    output logic [7:0]           rsp_result,
    output logic                 rsp_err,
    output logic                 rsp_timeout,
    output logic                 busy,
    output logic [2:0]           paddr,
    output logic [7:0]           pwdata,
    output logic                 psel,
    output logic                 penable,
    output logic                 pwrite,
    input  logic                 pready,
    input  logic [7:0]           prdata
);

    localparam int POLL_W = $clog2(POLL_MAX + 1);
    localparam int WAIT_W = $clog2(PREADY_MAX + 1);

    localparam logic [2:0]       ADDR_OPERAND = 3'd0;
    localparam logic [2:0]       ADDR_RESULT  = 3'd2;
    localparam logic [2:0]       ADDR_CONTROL = 3'd4;
    localparam logic [7:0]       START_CMD    = 8'h01;
    localparam logic [N_REQ-1:0] ACK_LSB      = {{(N_REQ-1){1'b0}}, 1'b1};

    typedef enum logic [2:0] {
        ST_IDLE     = 3'd0,
        ST_WR_OP    = 3'd1,
        ST_WR_START = 3'd2,
        ST_POLL     = 3'd3,
        ST_RD_RES   = 3'd4,
        ST_DONE     = 3'd5
    } state_t;

    state_t              state_r;
    logic                access_r;     // 0 = SETUP phase, 1 = ACCESS phase
    logic [ID_W-1:0]     rr_ptr_r;
    logic [ID_W-1:0]     id_r;
    logic [7:0]          operand_r;
    logic                err_r;
    logic [POLL_W-1:0]   poll_cnt_r;
    logic [WAIT_W-1:0]   wait_cnt_r;   // ACCESS cycles already spent without pready

    logic                apb_state_s;
    logic                xfer_done_s;
    logic                wait_expired_s;
    logic                poll_expired_s;
    logic                job_end_s;
    logic                job_tmo_s;
    state_t              next_apb_s;
    logic [ID_W-1:0]     grant_s;
    logic [7:0]          grant_operand_s;

    // APB address used by each transfer state
    function automatic logic [2:0] addr_of(input state_t st);
        logic [2:0] a;
        case (st)
            ST_WR_OP:    a = ADDR_OPERAND;
            ST_WR_START: a = ADDR_CONTROL;
            ST_POLL:     a = ADDR_CONTROL;
            ST_RD_RES:   a = ADDR_RESULT;
            default:     a = 3'd0;
        endcase
        return a;
    endfunction

    // APB direction used by each transfer state
    function automatic logic write_of(input state_t st);
        logic w;
        case (st)
            ST_WR_OP:    w = 1'b1;
            ST_WR_START: w = 1'b1;
            default:     w = 1'b0;
        endcase
        return w;
    endfunction

    // APB write data used by each transfer state (reads drive zero)
    function automatic logic [7:0] wdata_of(input state_t st, input logic [7:0] op);
        logic [7:0] d;
        case (st)
            ST_WR_OP:    d = op;
            ST_WR_START: d = START_CMD;
            default:     d = 8'h00;
        endcase
        return d;
    endfunction

    // First set request at or after the pointer, wrapping around
    function automatic logic [ID_W-1:0] rr_pick(input logic [N_REQ-1:0] r,
                                                input logic [ID_W-1:0]  ptr);
        logic [ID_W-1:0] cand;
        logic [ID_W-1:0] pick;
        logic            found;
        cand  = ptr;
        pick  = ptr;
        found = 1'b0;
        for (int k = 0; k < N_REQ; k++) begin
            if (!found && r[cand]) begin
                pick  = cand;
                found = 1'b1;
            end
            cand = (cand == ID_W'(N_REQ - 1)) ? '0 : cand + ID_W'(1'b1);
        end
        return pick;
    endfunction

    // Requester index following id, modulo N_REQ
    function automatic logic [ID_W-1:0] next_id(input logic [ID_W-1:0] id);
        return (id == ID_W'(N_REQ - 1)) ? '0 : id + ID_W'(1'b1);
    endfunction

    // Transfer completion and job-termination conditions
    always_comb begin
        apb_state_s    = (state_r == ST_WR_OP) || (state_r == ST_WR_START) ||
                         (state_r == ST_POLL)  || (state_r == ST_RD_RES);
        xfer_done_s    = apb_state_s && access_r && pready;
        wait_expired_s = apb_state_s && access_r && !pready &&
                         (wait_cnt_r == WAIT_W'(PREADY_MAX - 1));
        poll_expired_s = (state_r == ST_POLL) && xfer_done_s && !prdata[1] &&
                         (poll_cnt_r == POLL_W'(POLL_MAX - 1));
        job_end_s      = wait_expired_s || poll_expired_s ||
                         ((state_r == ST_RD_RES) && xfer_done_s);
        job_tmo_s      = wait_expired_s || poll_expired_s;
    end

    // State that follows a completed transfer
    always_comb begin
        next_apb_s = ST_IDLE;
        case (state_r)
            ST_WR_OP:    next_apb_s = ST_WR_START;
            ST_WR_START: next_apb_s = ST_POLL;
            ST_POLL: begin
                if (prdata[1]) begin
                    next_apb_s = ST_RD_RES;
                end else begin
                    next_apb_s = ST_POLL;
                end
            end
            ST_RD_RES:   next_apb_s = ST_DONE;
            default:     next_apb_s = ST_IDLE;
        endcase
    end

    // Round-robin grant candidate and its operand
    always_comb begin
        grant_s         = rr_pick(req, rr_ptr_r);
        grant_operand_s = req_operand[{grant_s, 3'b000} +: 8];
    end

    // Sequencer FSM with registered APB and response outputs
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r     <= ST_IDLE;
            access_r    <= 1'b0;
            rr_ptr_r    <= '0;
            id_r        <= '0;
            operand_r   <= 8'h00;
            err_r       <= 1'b0;
            poll_cnt_r  <= '0;
            wait_cnt_r  <= '0;
            ack         <= '0;
            rsp_valid   <= 1'b0;
            rsp_id      <= '0;
            rsp_result  <= 8'h00;
            rsp_err     <= 1'b0;
            rsp_timeout <= 1'b0;
            busy        <= 1'b0;
            paddr       <= 3'd0;
            pwdata      <= 8'h00;
            psel        <= 1'b0;
            penable     <= 1'b0;
            pwrite      <= 1'b0;
        end else begin
            rsp_valid <= 1'b0;
            ack       <= '0;
            case (state_r)
                ST_IDLE: begin
                    if (|req) begin
                        state_r    <= ST_WR_OP;
                        access_r   <= 1'b0;
                        id_r       <= grant_s;
                        operand_r  <= grant_operand_s;
                        err_r      <= 1'b0;
                        poll_cnt_r <= '0;
                        wait_cnt_r <= '0;
                        busy       <= 1'b1;
                        psel       <= 1'b1;
                        penable    <= 1'b0;
                        paddr      <= ADDR_OPERAND;
                        pwrite     <= 1'b1;
                        pwdata     <= grant_operand_s;
                    end
                end
                ST_WR_OP, ST_WR_START, ST_POLL, ST_RD_RES: begin
                    if (!access_r) begin
                        access_r   <= 1'b1;
                        penable    <= 1'b1;
                        wait_cnt_r <= '0;
                    end else if (job_end_s) begin
                        // Result/err only meaningful on a clean finish
                        state_r     <= ST_DONE;
                        access_r    <= 1'b0;
                        psel        <= 1'b0;
                        penable     <= 1'b0;
                        pwrite      <= 1'b0;
                        paddr       <= 3'd0;
                        pwdata      <= 8'h00;
                        rsp_valid   <= 1'b1;
                        ack         <= ACK_LSB << id_r;
                        rsp_id      <= id_r;
                        rsp_timeout <= job_tmo_s;
                        rsp_result  <= job_tmo_s ? 8'h00 : prdata;
                        rsp_err     <= job_tmo_s ? 1'b0 : err_r;
                    end else if (xfer_done_s) begin
                        // Back-to-back: psel stays high into the next SETUP
                        state_r  <= next_apb_s;
                        access_r <= 1'b0;
                        penable  <= 1'b0;
                        paddr    <= addr_of(next_apb_s);
                        pwrite   <= write_of(next_apb_s);
                        pwdata   <= wdata_of(next_apb_s, operand_r);
                        if (state_r == ST_POLL) begin
                            if (prdata[1]) begin
                                err_r <= prdata[7];
                            end else if (poll_cnt_r != POLL_W'(POLL_MAX)) begin
                                poll_cnt_r <= poll_cnt_r + POLL_W'(1'b1);
                            end
                        end
                    end else if (wait_cnt_r != WAIT_W'(PREADY_MAX)) begin
                        wait_cnt_r <= wait_cnt_r + WAIT_W'(1'b1);
                    end
                end
                ST_DONE: begin
                    state_r  <= ST_IDLE;
                    busy     <= 1'b0;
                    rr_ptr_r <= next_id(id_r);
                end
                default: begin
                    // Unreachable encodings recover to a quiet IDLE
                    state_r  <= ST_IDLE;
                    access_r <= 1'b0;
                    busy     <= 1'b0;
                    psel     <= 1'b0;
                    penable  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_conv_apb_sequencer.sv
// -----------------------------------------------------------------------------
// tb_conv_apb_sequencer
//
// Drives conv_apb_sequencer against a behavioural converter slave. Each
// response is compared against expectations derived from the job rules:
//   - round-robin order
//   - result is the Gray code of the operand
//   - the APB transaction list per job
//   - the ACCESS-cycle budget
//   - timeout behaviour
// -----------------------------------------------------------------------------
module tb_conv_apb_sequencer;

    localparam int N_REQ      = 2;
    localparam int POLL_MAX   = 64;
    localparam int PREADY_MAX = 16;

    logic               clk;
    logic               rst_n;
    logic [N_REQ-1:0]   req;
    logic [8*N_REQ-1:0] req_operand;
    logic [N_REQ-1:0]   ack;
    logic               rsp_valid;
    logic [0:0]         rsp_id;
    logic [7:0]         rsp_result;
    logic               rsp_err;
    logic               rsp_timeout;
    logic               busy;
    logic [2:0]         paddr;
    logic [7:0]         pwdata;
    logic               psel;
    logic               penable;
    logic               pwrite;
    logic               pready;
    logic [7:0]         prdata;

    conv_apb_sequencer #(
        .N_REQ(N_REQ), .POLL_MAX(POLL_MAX), .PREADY_MAX(PREADY_MAX)
    ) dut (
        .clk(clk), .rst_n(rst_n), .req(req), .req_operand(req_operand),
        .ack(ack), .rsp_valid(rsp_valid), .rsp_id(rsp_id),
        .rsp_result(rsp_result), .rsp_err(rsp_err), .rsp_timeout(rsp_timeout),
        .busy(busy), .paddr(paddr), .pwdata(pwdata), .psel(psel),
        .penable(penable), .pwrite(pwrite), .pready(pready), .prdata(prdata)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_bad = 0;

    // Slave configuration (written by the stimulus)
    int  ws_cfg      = 0;     // pready-low cycles per transfer
    bit  never_ready = 1'b0;
    int  done_after  = 1;     // poll number that sees the end flag, 0 = never
    bit  err_cfg     = 1'b0;

    // Slave / monitor state
    logic [7:0]  op_reg = 8'h00;
    logic [7:0]  res_reg = 8'h00;
    int          polls_done = 0;
    int          acc_cnt = 0;
    int          access_cycles = 0;
    int          stab_err = 0;
    int          dbl_ack = 0;
    int          ack_err = 0;
    int          ack_total = 0;
    logic [2:0]  hold_addr;
    logic        hold_wr;
    logic [7:0]  hold_wd;
    logic [11:0] apb_log[$];

    // Stimulus bookkeeping
    int          log_base = 0;
    int          acc_base = 0;
    int          ptr_m = 0;
    int          first_lat = 0;
    logic        first_busy;
    logic [13:0] first_setup;
    logic [7:0]  served;

    function automatic logic [7:0] gray_of(input logic [7:0] b);
        logic [7:0] g;
        g[7] = b[7];
        for (int i = 0; i < 7; i++) g[i] = b[i+1] ^ b[i];
        return g;
    endfunction

    function automatic int model_pick(input logic [N_REQ-1:0] pend, input int ptr);
        for (int k = 0; k < N_REQ; k++) begin
            if (pend[(ptr + k) % N_REQ]) return (ptr + k) % N_REQ;
        end
        return 0;
    endfunction

    function automatic logic [N_REQ-1:0] onehot(input int id);
        logic [N_REQ-1:0] v;
        v = '0;
        v[id] = 1'b1;
        return v;
    endfunction

    // Converter slave model, transfer logger and protocol monitors
    always @(negedge clk) begin
        if (psel === 1'b1 && penable === 1'b1) begin
            if (acc_cnt == 0) begin
                hold_addr = paddr;
                hold_wr   = pwrite;
                hold_wd   = pwdata;
            end else if (paddr !== hold_addr || pwrite !== hold_wr || pwdata !== hold_wd) begin
                stab_err++;
            end
            pready = !never_ready && (acc_cnt >= ws_cfg);
            case (paddr)
                3'd0:    prdata = op_reg;
                3'd2:    prdata = res_reg;
                3'd4:    prdata = (err_cfg ? 8'h80 : 8'h00) |
                                  (((done_after != 0) && (polls_done + 1 >= done_after)) ? 8'h02 : 8'h00);
                default: prdata = 8'h00;
            endcase
            if (pready) begin
                if (pwrite) begin
                    apb_log.push_back({1'b1, paddr, pwdata});
                    if (paddr == 3'd0) begin
                        op_reg = pwdata;
                    end else if (paddr == 3'd4 && pwdata[0]) begin
                        res_reg    = op_reg ^ (op_reg >> 1);
                        polls_done = 0;
                    end
                end else begin
                    apb_log.push_back({1'b0, paddr, prdata});
                    if (paddr == 3'd4) polls_done++;
                end
            end
            acc_cnt++;
            access_cycles++;
        end else begin
            pready  = 1'b0;
            acc_cnt = 0;
        end
        if ($countones(ack) > 1) dbl_ack++;
        if (ack !== '0) begin
            ack_total++;
            if (rsp_valid !== 1'b1 || ack !== onehot(int'(rsp_id))) ack_err++;
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        n_cmp++;
        assert (obs === expv) else begin
            n_bad++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
        end
    endtask

    task automatic wait_rsp(input int bound, output int n, output bit ok);
        n  = 0;
        ok = 1'b0;
        while (n < bound && !ok) begin
            @(negedge clk);
            n++;
            if (n == 1) begin
                first_busy  = busy;
                first_setup = {psel, penable, pwrite, paddr, pwdata};
            end
            if (rsp_valid === 1'b1) ok = 1'b1;
        end
        chk("rsp_within_bound", {31'd0, ok}, 32'd1);
    endtask

    // Compare the response and the APB traffic of the job just finished
    task automatic check_job(input int exp_id, input logic [7:0] op);
        logic [11:0] expq[$];
        bit          tmo;
        bit          seq_ok;
        int          npoll;
        int          acc_exp;
        tmo = never_ready || (done_after == 0);
        if (!never_ready) begin
            expq.push_back({1'b1, 3'd0, op});
            expq.push_back({1'b1, 3'd4, 8'h01});
            npoll = (done_after == 0) ? POLL_MAX : done_after;
            for (int p = 1; p <= npoll; p++) begin
                expq.push_back({1'b0, 3'd4, (err_cfg ? 8'h80 : 8'h00) |
                               ((done_after != 0 && p == npoll) ? 8'h02 : 8'h00)});
            end
            if (done_after != 0) expq.push_back({1'b0, 3'd2, gray_of(op)});
        end
        acc_exp = never_ready ? PREADY_MAX : (ws_cfg + 1) * expq.size();
        seq_ok = (apb_log.size() - log_base) == expq.size();
        for (int i = 0; seq_ok && i < expq.size(); i++) begin
            if (apb_log[log_base + i] !== expq[i]) seq_ok = 1'b0;
        end
        chk("rsp_id",      {31'd0, rsp_id}, exp_id);
        chk("rsp_result",  {24'd0, rsp_result}, tmo ? 32'd0 : {24'd0, gray_of(op)});
        chk("rsp_err",     {31'd0, rsp_err}, (tmo || !err_cfg) ? 32'd0 : 32'd1);
        chk("rsp_timeout", {31'd0, rsp_timeout}, {31'd0, tmo});
        chk("ack_onehot",  {30'd0, ack}, {30'd0, onehot(exp_id)});
        chk("apb_seq",     {31'd0, seq_ok}, 32'd1);
        chk("access_cycles", access_cycles - acc_base, acc_exp);
        log_base = apb_log.size();
        acc_base = access_cycles;
    endtask

    // Raise the requests in mask and serve njobs of them in round-robin order
    task automatic run_jobs(input logic [N_REQ-1:0] mask, input bit hold, input int njobs,
                            input logic [7:0] op0, input logic [7:0] op1);
        logic [N_REQ-1:0] pending;
        int  exp_id;
        int  lat;
        bit  ok;
        pending     = mask;
        served      = 8'h00;
        req_operand = {op1, op0};
        req         = mask;
        for (int j = 0; j < njobs; j++) begin
            exp_id = model_pick(pending, ptr_m);
            wait_rsp(2000, lat, ok);
            if (!ok) begin
                req = '0;
                return;
            end
            if (j == 0) first_lat = lat;
            served[j] = rsp_id[0];
            check_job(exp_id, (exp_id == 1) ? op1 : op0);
            ptr_m = (exp_id + 1) % N_REQ;
            if (!hold) begin
                pending[exp_id] = 1'b0;
                req[exp_id]     = 1'b0;
            end
        end
        req = '0;
    endtask

    initial begin
        int  n;
        bit  ok;
        int  acks_before;
        logic [N_REQ-1:0] m;
        rst_n       = 1'b0;
        req         = '0;
        req_operand = '0;
        pready      = 1'b0;
        prdata      = 8'h00;

        // Reset state
        repeat (3) @(negedge clk);
        chk("reset_psel",      {31'd0, psel}, 32'd0);
        chk("reset_penable",   {31'd0, penable}, 32'd0);
        chk("reset_busy",      {31'd0, busy}, 32'd0);
        chk("reset_ack",       {30'd0, ack}, 32'd0);
        chk("reset_rsp_valid", {31'd0, rsp_valid}, 32'd0);
        chk("reset_outputs",   {15'd0, pwrite, paddr, pwdata, rsp_result, rsp_err, rsp_timeout}, 32'd0);
        rst_n = 1'b1;
        @(negedge clk);

        // Basic job: operand 0x0B, end flag on the first poll, zero wait
        ws_cfg = 0; never_ready = 1'b0; done_after = 1; err_cfg = 1'b0;
        run_jobs(2'b01, 1'b0, 1, 8'h0B, 8'h00);
        chk("t1_result_0e",    {24'd0, rsp_result}, 32'h0E);
        chk("t1_first_busy",   {31'd0, first_busy}, 32'd1);
        chk("t1_first_setup",  {18'd0, first_setup}, {18'd0, 1'b1, 1'b0, 1'b1, 3'd0, 8'h0B});
        // grant cycle + 8 APB cycles + DONE = 10 cycles
        chk("t1_latency",      first_lat + 1, 32'd10);
        @(negedge clk);
        chk("t1_ack_one_cycle", {30'd0, ack}, 32'd0);
        chk("t1_busy_cleared",  {31'd0, busy}, 32'd0);
        chk("t1_rsp_hold",      {24'd0, rsp_result}, 32'h0E);

        // Serve requester 1 alone so that the pointer wraps back to 0
        run_jobs(2'b10, 1'b0, 1, 8'h00, 8'($urandom));

        // Both requests held: strict alternation 0,1,0,1
        run_jobs(2'b11, 1'b1, 4, 8'($urandom), 8'($urandom));
        chk("t2_order", {28'd0, served[3:0]}, 32'b1010);

        // Error flag set with the end flag
        done_after = 2; err_cfg = 1'b1;
        run_jobs(2'b01, 1'b0, 1, 8'($urandom), 8'h00);
        chk("t4_err", {31'd0, rsp_err}, 32'd1);

        // End flag never set: POLL_MAX polls then timeout
        done_after = 0; err_cfg = 1'b0;
        run_jobs(2'b10, 1'b0, 1, 8'h00, 8'($urandom));
        chk("t3_timeout", {31'd0, rsp_timeout}, 32'd1);

        // Three wait states on every transfer
        done_after = 1; ws_cfg = 3;
        run_jobs(2'b01, 1'b0, 1, 8'($urandom), 8'h00);

        // pready never asserted: abort after PREADY_MAX ACCESS cycles
        never_ready = 1'b1;
        run_jobs(2'b10, 1'b0, 1, 8'h00, 8'($urandom));
        chk("t5_psel_dropped", {31'd0, psel}, 32'd0);
        never_ready = 1'b0;

        // Randomized rounds
        for (int r = 0; r < 8; r++) begin
            ws_cfg     = $urandom_range(0, 2);
            done_after = $urandom_range(1, 4);
            err_cfg    = 1'($urandom_range(0, 1));
            m          = 2'($urandom_range(1, 3));
            run_jobs(m, 1'b0, $countones(m), 8'($urandom), 8'($urandom));
        end

        // Reset during POLL ACCESS
        ws_cfg = 1; done_after = 0; err_cfg = 1'b0;
        req_operand = {8'h00, 8'($urandom)};
        req = 2'b01;
        n = 0; ok = 1'b0;
        while (n < 200 && !ok) begin
            @(negedge clk);
            n++;
            if (psel === 1'b1 && penable === 1'b1 && paddr === 3'd4 && pwrite === 1'b0) ok = 1'b1;
        end
        chk("t6_reached_poll", {31'd0, ok}, 32'd1);
        acks_before = ack_total;
        rst_n = 1'b0;
        #1;
        chk("t6_psel_async",    {31'd0, psel}, 32'd0);
        chk("t6_penable_async", {31'd0, penable}, 32'd0);
        req = 2'b00;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        repeat (3) @(negedge clk);
        chk("t6_no_ack", ack_total, acks_before);
        chk("t6_idle_busy", {31'd0, busy}, 32'd0);
        log_base = apb_log.size();
        acc_base = access_cycles;
        ptr_m = 0;
        ws_cfg = 0; done_after = 1;
        run_jobs(2'b10, 1'b0, 1, 8'h00, 8'($urandom));

        // Global protocol monitors
        chk("apb_stable_in_access", stab_err, 32'd0);
        chk("single_ack",           dbl_ack, 32'd0);
        chk("ack_matches_rsp",      ack_err, 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
